frame_sync_1011: RTL and testbench

Serial frame synchronizer built around a 1011 sync-word detector. It hunts the incoming bit stream for the sync word 1011 and, once found, sequences the stream as repeating frames of a 4-bit sync word followed by PAYLOAD_BITS payload bits. It delivers each payload word in parallel and declares and holds frame lock with flywheel tolerance. It sits between a serial bit source and downstream word-level consumers.

---
 rtl/frame_sync_pkg.sv | 20 ++
 rtl/seq_det_1011.sv | 35 +++
 rtl/frame_sync_1011.sv | 140 ++++++++++++++
 tb/tb_frame_sync_1011.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_sync_pkg.sv
// Shared types and constants for the 1011 frame synchronizer.
// Imported by the detector and the top-level sequencer.
package frame_sync_pkg;

    localparam logic [3:0] SYNC_WORD = 4'b1011;

    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK
    } state_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_1,
        D_10,
        D_101
    } det_state_t;

endpackage

// File: rtl/seq_det_1011.sv
// Overlapping 1011 sequence detector with enable and synchronous clear.
// State tracks the longest matched prefix; match is decoded from state and bit.
module seq_det_1011
    import frame_sync_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic in_bit,
    output logic match
);

    det_state_t st;

    assign match = en && in_bit && (st == D_101);

    // Prefix tracking; clear wins over enable, overlap resumes at prefix "1" or "10".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= D_IDLE;
        end else if (clr) begin
            st <= D_IDLE;
        end else if (en) begin
            unique case (st)
                D_IDLE: st <= in_bit ? D_1   : D_IDLE;
                D_1:    st <= in_bit ? D_1   : D_10;
                D_10:   st <= in_bit ? D_101 : D_IDLE;
                D_101:  st <= in_bit ? D_1   : D_10;
                default: st <= D_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/frame_sync_1011.sv
// Serial frame synchronizer: hunts for 1011, then sequences sync + payload
// frames, delivers payload words in parallel and tracks lock with flywheel.
module frame_sync_1011
    import frame_sync_pkg::*;
#(
    parameter int PAYLOAD_BITS = 8,
    parameter int LOCK_COUNT   = 3,
    parameter int MISS_LIMIT   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_bit,
    input  logic                    in_valid,
    output logic [PAYLOAD_BITS-1:0] payload,
    output logic                    payload_valid,
    output logic                    locked,
    output logic                    frame_err
);

    localparam int BW = $clog2(PAYLOAD_BITS + 1);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [BW-1:0] BIT_LAST  = BW'(PAYLOAD_BITS - 1);
    localparam logic [GW-1:0] GOOD_MAX  = GW'(LOCK_COUNT);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

    state_t                  state;
    logic [BW-1:0]           bit_cnt;
    logic [PAYLOAD_BITS-1:0] pay_sh;
    logic [PAYLOAD_BITS-1:0] pay_nxt;
    logic [2:0]              sync_sh;
    logic [3:0]              sync_nxt;
    logic [2:0]              sync_cnt;
    logic [GW-1:0]           good_cnt;
    logic [MW-1:0]           miss_cnt;

    logic det_en;
    logic det_clr;
    logic match;
    logic sync_done;
    logic sync_ok;
    logic fly;

    assign det_en    = in_valid && (state == HUNT);
    assign sync_nxt  = {sync_sh, in_bit};
    assign sync_done = in_valid && (state == CHECK) && (sync_cnt == 3'd3);
    assign sync_ok   = (sync_nxt == SYNC_WORD);
    assign fly       = locked && (miss_cnt < MISS_LAST);
    // Failed sync word drops to hunt; its bits are not replayed into the detector.
    assign det_clr   = sync_done && !sync_ok && !fly;

    // Next payload shift value, MSB-first (first received bit ends in MSB).
    always_comb begin
        pay_nxt    = pay_sh << 1;
        pay_nxt[0] = in_bit;
    end

    seq_det_1011 u_det (
        .clk    (clk),
        .reset  (reset),
        .en     (det_en),
        .clr    (det_clr),
        .in_bit (in_bit),
        .match  (match)
    );

    // Framing FSM with shift registers, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= HUNT;
            bit_cnt       <= '0;
            pay_sh        <= '0;
            sync_sh       <= '0;
            sync_cnt      <= '0;
            good_cnt      <= '0;
            miss_cnt      <= '0;
            payload       <= '0;
            payload_valid <= 1'b0;
            locked        <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            payload_valid <= 1'b0;
            frame_err     <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (match) begin
                            good_cnt <= GW'(1);
                            miss_cnt <= '0;
                            bit_cnt  <= '0;
                            locked   <= (LOCK_COUNT == 1);
                            state    <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        pay_sh <= pay_nxt;
                        if (bit_cnt == BIT_LAST) begin
                            payload       <= pay_nxt;
                            payload_valid <= 1'b1;
                            sync_sh       <= '0;
                            sync_cnt      <= '0;
                            state         <= CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    CHECK: begin
                        sync_sh  <= sync_nxt[2:0];
                        sync_cnt <= sync_cnt + 3'd1;
                        if (sync_cnt == 3'd3) begin
                            if (sync_ok) begin
                                if (good_cnt != GOOD_MAX)
                                    good_cnt <= good_cnt + 1'b1;
                                if (good_cnt >= GOOD_LAST)
                                    locked <= 1'b1;
                                miss_cnt <= '0;
                                bit_cnt  <= '0;
                                state    <= PAYLOAD;
                            end else if (fly) begin
                                miss_cnt <= miss_cnt + 1'b1;
                                bit_cnt  <= '0;
                                state    <= PAYLOAD;
                            end else begin
                                frame_err <= 1'b1;
                                locked    <= 1'b0;
                                good_cnt  <= '0;
                                miss_cnt  <= '0;
                                state     <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_sync_1011.sv
// Scoreboard bench for frame_sync_1011: directed frames with expected words
// queued at stimulus time and checked by an output monitor.
module tb_frame_sync_1011;
    import frame_sync_pkg::*;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in_bit;
    logic       in_valid;
    logic [7:0] payload;
    logic       payload_valid;
    logic       locked;
    logic       frame_err;
    logic [7:0] payload2;
    logic       payload_valid2;
    logic       locked2;
    logic       frame_err2;

    exp_t sb[$];
    int   tests;
    int   fails;

    frame_sync_1011 #(
        .PAYLOAD_BITS (8),
        .LOCK_COUNT   (3),
        .MISS_LIMIT   (2)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .in_bit        (in_bit),
        .in_valid      (in_valid),
        .payload       (payload),
        .payload_valid (payload_valid),
        .locked        (locked),
        .frame_err     (frame_err)
    );

    frame_sync_1011 #(
        .PAYLOAD_BITS (8),
        .LOCK_COUNT   (1),
        .MISS_LIMIT   (2)
    ) u_dut1 (
        .clk           (clk),
        .reset         (reset),
        .in_bit        (in_bit),
        .in_valid      (in_valid),
        .payload       (payload2),
        .payload_valid (payload_valid2),
        .locked        (locked2),
        .frame_err     (frame_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = 8'h00;
        sb.push_back(e);
    endtask

    task automatic send(input logic b);
        in_bit   = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_gap(input logic b);
        idle($urandom_range(0, 3));
        send(b);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send(v[i]);
    endtask

    task automatic send_bits_gap(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_gap(v[i]);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && (payload_valid || frame_err)) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got pv=%0b fe=%0b data=%0h expected none",
                         payload_valid, frame_err, payload);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_err != frame_err || e.is_err == payload_valid ||
                    (!e.is_err && payload !== e.data)) begin
                    fails++;
                    $display("FAIL sb_pulse: got fe=%0b pv=%0b data=%0h expected err=%0b data=%0h",
                             frame_err, payload_valid, payload, e.is_err, e.data);
                end
            end
        end
    end

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        in_bit   = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_payload", 32'(payload), 32'h0);
        chk("rst_pv", 32'(payload_valid), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_locked_l1", 32'(locked2), 32'h0);
        chk("rst_state", 32'(u_dut.state), 32'(HUNT));
        reset = 1'b0;

        send_bits(8'h00, 8);
        chk("zeros_locked", 32'(locked), 32'h0);
        chk("zeros_state", 32'(u_dut.state), 32'(HUNT));

        // Acquire and lock over three good frames.
        send_bits(8'hB, 4);
        chk("hunt_state", 32'(u_dut.state), 32'(PAYLOAD));
        chk("hunt_locked", 32'(locked), 32'h0);
        chk("hunt_locked_l1", 32'(locked2), 32'h1);
        push_word(8'hA5);
        send_bits(8'hA5, 8);
        send_bits(8'hB, 4);
        chk("sync2_locked", 32'(locked), 32'h0);
        push_word(8'h3C);
        send_bits(8'h3C, 8);
        send_bits(8'h5, 3);
        chk("sync3_pre_locked", 32'(locked), 32'h0);
        send(1'b1);
        chk("sync3_locked", 32'(locked), 32'h1);
        push_word(8'hFF);
        send_bits(8'hFF, 8);

        // One bad sync while locked is flywheeled.
        send_bits(8'h3, 4);
        chk("fly_locked", 32'(locked), 32'h1);
        chk("fly_miss", 32'(u_dut.miss_cnt), 32'h1);
        push_word(8'h5A);
        send_bits(8'h5A, 8);
        send_bits(8'hB, 4);
        chk("fly_clear_miss", 32'(u_dut.miss_cnt), 32'h0);
        push_word(8'hC3);
        send_bits(8'hC3, 8);

        // Two consecutive bad syncs lose lock.
        send_bits(8'h0, 4);
        chk("bad1_locked", 32'(locked), 32'h1);
        push_word(8'h12);
        send_bits(8'h12, 8);
        push_err();
        send_bits(8'hF, 4);
        chk("bad2_ferr", 32'(frame_err), 32'h1);
        chk("bad2_locked", 32'(locked), 32'h0);
        chk("bad2_state", 32'(u_dut.state), 32'(HUNT));
        idle(1);
        chk("ferr_fall", 32'(frame_err), 32'h0);
        send_bits(8'hB, 4);
        chk("reacq_state", 32'(u_dut.state), 32'(PAYLOAD));
        push_word(8'h81);
        send_bits(8'h81, 8);

        // Unlocked with a bad first sync word drops straight to hunt.
        push_err();
        send_bits(8'h6, 4);
        chk("unl_ferr", 32'(frame_err), 32'h1);
        chk("unl_locked", 32'(locked), 32'h0);
        chk("unl_state", 32'(u_dut.state), 32'(HUNT));

        // Overlapping 101011 with random gaps.
        send_bits_gap(8'h2B, 6);
        chk("ovl_state", 32'(u_dut.state), 32'(PAYLOAD));
        push_word(8'h96);
        send_bits_gap(8'h96, 8);
        idle(5);
        chk("gap_payload", 32'(payload), 32'h96);
        chk("gap_pv", 32'(payload_valid), 32'h0);
        chk("gap_state", 32'(u_dut.state), 32'(CHECK));

        // Reach lock, then reset in the middle of a payload.
        send_bits(8'hB, 4);
        push_word(8'h44);
        send_bits(8'h44, 8);
        send_bits(8'hB, 4);
        chk("pre_rst_locked", 32'(locked), 32'h1);
        send_bits(8'hA, 4);
        reset = 1'b1;
        #1;
        chk("mid_rst_locked", 32'(locked), 32'h0);
        chk("mid_rst_pv", 32'(payload_valid), 32'h0);
        chk("mid_rst_payload", 32'(payload), 32'h0);
        chk("mid_rst_state", 32'(u_dut.state), 32'(HUNT));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        send_bits(8'h0, 4);
        idle(2);
        chk("post_rst_locked", 32'(locked), 32'h0);
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
